// File: rtl/data_ram_wait.sv
// rtl/data_ram_wait.sv - byte-lane data RAM with req/ready/ack handshake and programmable wait states
module data_ram_wait #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic                ready_o,
    output logic                ack_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   data_o
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic [3:0] r_cnt;

    // request fields captured on the accept edge
    logic                  r_we;
    logic                  r_mis;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [NB-1:0]         r_sel;
    logic [DATA_W-1:0]     r_data;

    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_in_mis;
    logic [DEPTH_LOG2-1:0] w_in_idx;

    // fields actually used on the access edge (inputs directly when WAIT_CYCLES=0)
    logic                  w_acc_we;
    logic                  w_acc_mis;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [NB-1:0]         w_acc_sel;
    logic [DATA_W-1:0]     w_acc_data;

    assign w_in_idx = addr_i[DEPTH_LOG2+LSB-1:LSB];

    generate
        if (LSB > 0) begin : g_mis
            assign w_in_mis = |addr_i[LSB-1:0];
        end else begin : g_nomis
            assign w_in_mis = 1'b0;
        end
        if (ADDR_W > DEPTH_LOG2 + LSB) begin : g_alias
            // upper address bits are deliberately ignored so addresses wrap modulo depth
            logic w_unused_addr;
            assign w_unused_addr = ^addr_i[ADDR_W-1:DEPTH_LOG2+LSB];
        end
    endgenerate

    assign w_accept = (r_state == S_IDLE) && req_i;

    // access happens on the edge entering RESP; a reset held across that edge cancels it
    assign w_access = !rst && ((w_accept && (WAIT_N == 4'd0)) ||
                               ((r_state == S_WAIT) && (r_cnt == 4'd1)));

    assign w_acc_we   = (r_state == S_IDLE) ? we_i     : r_we;
    assign w_acc_mis  = (r_state == S_IDLE) ? w_in_mis : r_mis;
    assign w_acc_idx  = (r_state == S_IDLE) ? w_in_idx : r_idx;
    assign w_acc_sel  = (r_state == S_IDLE) ? sel_i    : r_sel;
    assign w_acc_data = (r_state == S_IDLE) ? data_i   : r_data;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        w_next  = r_state;
        ready_o = 1'b0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_i) begin
                    w_next = (WAIT_N == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                ack_o  = 1'b1;
                err_o  = r_err;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // wait-state counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= WAIT_N;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // capture the request on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_mis  <= 1'b0;
            r_idx  <= '0;
            r_sel  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_we   <= we_i;
            r_mis  <= w_in_mis;
            r_idx  <= w_in_idx;
            r_sel  <= sel_i;
            r_data <= data_i;
        end
    end

    // byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_access && w_acc_we && !w_acc_mis) begin
            for (int k = 0; k < NB; k++) begin
                if (w_acc_sel[k]) begin
                    r_mem[w_acc_idx][8*k +: 8] <= w_acc_data[8*k +: 8];
                end
            end
        end
    end

    // response data and error flag, updated only on the access edge and held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_err   <= w_acc_mis;
            r_rdata <= (!w_acc_we && !w_acc_mis) ? r_mem[w_acc_idx] : '0;
        end
    end

    assign data_o = r_rdata;

endmodule

// File: tb/tb_data_ram_wait.sv
// tb/tb_data_ram_wait.sv - self-checking bench for data_ram_wait
module tb_data_ram_wait;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req, we, ready, ack, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;

    logic        req0, we0, ready0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  sel0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model_a [int];

    data_ram_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .ready_o(ready), .ack_o(ack), .err_o(err), .data_o(rdata)
    );

    data_ram_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .sel_i(sel0),
        .data_i(wdata0), .ready_o(ready0), .ack_o(ack0), .err_o(err0), .data_o(rdata0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // memory is a plain array of words; byte address / 4, modulo 1024 words
    task automatic model_apply(input bit w, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] exp_d, output logic exp_e);
        int idx;
        logic [31:0] cur;
        idx   = int'((a / 4) % 1024);
        exp_e = (a % 4) != 0;
        exp_d = 32'h0;
        if (!exp_e) begin
            if (w) begin
                cur = model_a.exists(idx) ? model_a[idx] : 32'h0;
                for (int k = 0; k < 4; k++)
                    if (s[k]) cur[8*k +: 8] = d[8*k +: 8];
                model_a[idx] = cur;
            end else begin
                exp_d = model_a[idx];
            end
        end
    endtask

    // one transaction on the wait-state DUT; entered and left at a negedge with the DUT idle
    task automatic op(input string tag, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] got_d);
        logic [31:0] ed;
        logic        ee;
        int          n;
        bit          seen;
        model_apply(w, a, s, d, ed, ee);
        chk({tag, " ready"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; addr = a; sel = s; wdata = d;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            req = 1'b0;
            n++;
            seen = ack;
        end
        chk({tag, " latency"}, 32'(n), 32'(W + 1));
        chk({tag, " err"}, 32'(err), 32'(ee));
        chk({tag, " data"}, rdata, ed);
        got_d = rdata;
        @(negedge clk);
        chk({tag, " ack_once"}, {30'd0, ack, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] b2b_d [8];
        logic [31:0] expq [$];
        int          pool [8];
        int          item, acks, idx, late;
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          w;

        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; wdata0 = '0;
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst data", rdata, 32'd0);
        chk("rst ready0", 32'(ready0), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // full write then read back
        op("t2 wr", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, got);
        op("t2 rd", 1'b0, 32'h10, 4'hF, 32'h0, got);
        chk("t2 const", got, 32'hDEADBEEF);

        // byte lanes
        op("t3 wr_full", 1'b1, 32'h20, 4'hF, 32'h11223344, got);
        op("t3 wr_lane", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, got);
        op("t3 rd", 1'b0, 32'h20, 4'hF, 32'h0, got);
        chk("t3 const", got, 32'h11BB33DD);

        // misaligned
        op("t4 rd_mis", 1'b0, 32'h22, 4'hF, 32'h0, got);
        op("t4 wr_mis", 1'b1, 32'h21, 4'hF, 32'h0, got);
        op("t4 rd_chk", 1'b0, 32'h20, 4'hF, 32'h0, got);
        chk("t4 const", got, 32'h11BB33DD);

        // address alias
        op("t5 wr", 1'b1, 32'h1000, 4'hF, 32'h5A5AC3C3, got);
        op("t5 rd", 1'b0, 32'h0000, 4'hF, 32'h0, got);
        chk("t5 const", got, 32'h5A5AC3C3);

        // reset in the middle of a write drops it
        op("t1 wr", 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, got);
        req = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1 ready", 32'(ready), 32'd1);
        chk("t1 ack", 32'(ack), 32'd0);
        chk("t1 data", rdata, 32'd0);
        rst = 1'b0;
        late = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) late++;
        end
        chk("t1 late_ack", 32'(late), 32'd0);
        op("t1 rd", 1'b0, 32'h40, 4'hF, 32'h0, got);
        chk("t1 const", got, 32'hCAFEF00D);

        // randomized traffic over a pool of prefilled words
        for (int i = 0; i < 8; i++) begin
            pool[i] = 512 + i * 37 + int'($urandom_range(0, 30));
            op("rnd fill", 1'b1, 32'(pool[i] * 4), 4'hF, $urandom, got);
        end
        for (int i = 0; i < 40; i++) begin
            idx = pool[$urandom_range(0, 7)];
            a = (32'($urandom_range(0, 3)) << 12) | 32'(idx * 4);
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            d = $urandom;
            op($sformatf("rnd %0d", i), w, a, s, d, got);
        end

        // back-to-back with req held high, zero wait states: writes
        for (int i = 0; i < 8; i++) b2b_d[i] = $urandom;
        item = 0;
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b2b_w ack k=%0d", k), 32'(ack0), 32'(k % 2));
            if (ack0) acks++;
            if (ready0 && item < 8) begin
                req0 = 1'b1; we0 = 1'b1; sel0 = 4'hF;
                addr0 = 32'h100 + 32'(item * 4);
                wdata0 = b2b_d[item];
                item++;
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        chk("b2b_w acks", 32'(acks), 32'd8);
        chk("b2b_w ack_end", 32'(ack0), 32'd0);
        @(negedge clk);

        // back-to-back reads of the same words
        item = 0;
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b2b_r ack k=%0d", k), 32'(ack0), 32'(k % 2));
            if (ack0) begin
                acks++;
                if (expq.size() > 0) chk($sformatf("b2b_r data %0d", acks), rdata0, expq.pop_front());
            end
            if (ready0 && item < 8) begin
                req0 = 1'b1; we0 = 1'b0; sel0 = 4'hF;
                addr0 = 32'h100 + 32'(item * 4);
                wdata0 = 32'h0;
                expq.push_back(b2b_d[item]);
                item++;
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        chk("b2b_r acks", 32'(acks), 32'd8);
        chk("b2b_r pending", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
